// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates the instruction-fetch and data-stage ports onto
// one single-master memory bus. One bus cycle at a time; the data stage wins
// a simultaneous request. The optional bus-timeout abort is compiled in when
// the BUS_TIMEOUT_EN macro is defined; otherwise BUSY waits for ack forever.
//
// Bus handshake: a cycle is in progress while bus_cyc_o/bus_stb_o are high.
// The slave completes it by raising bus_ack_i for one clock. The request
// signals (we/sel/addr/data) stay stable until that ack (or a timeout abort).
// bus_ack_i is ignored whenever no cycle is in progress.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch port
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_stall_req_o,
    // data-stage port
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stall_req_o,
    // memory bus
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o,
    // debug view of the FSM
    output logic [1:0]  dbg_state_o,
    output logic [1:0]  dbg_grant_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_INST = 2'd1,
        G_DATA = 2'd2
    } grant_t;

    state_t      state_q, state_d;
    grant_t      grant_q, grant_d;

    // latched request driven onto the bus during BUSY
    logic        req_we_q;
    logic [3:0]  req_sel_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_data_q;

    logic        latch_req;
    logic        lat_we;
    logic [3:0]  lat_sel;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;

    logic        complete;   // ack seen in BUSY
    logic        abort;      // timeout reached in BUSY without ack
    logic        timeout_hit;

    logic [31:0] if_data_q;
    logic [31:0] mem_data_q;

    // FSM state and grant registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= G_NONE;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // next-state, grant selection and request latching decisions
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        latch_req = 1'b0;
        lat_we    = 1'b0;
        lat_sel   = 4'b0000;
        lat_addr  = 32'h0;
        lat_data  = 32'h0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_ce_i) begin
                    // data stage has priority over fetch
                    state_d   = S_BUSY;
                    grant_d   = G_DATA;
                    latch_req = 1'b1;
                    lat_we    = mem_we_i;
                    lat_sel   = mem_sel_i;
                    lat_addr  = mem_addr_i;
                    lat_data  = mem_data_i;
                end else if (if_ce_i) begin
                    state_d   = S_BUSY;
                    grant_d   = G_INST;
                    latch_req = 1'b1;
                    lat_we    = 1'b0;
                    lat_sel   = 4'b1111;
                    lat_addr  = if_addr_i;
                    lat_data  = 32'h0;
                end
            end
            S_BUSY: begin
                // ack wins over a timeout landing in the same cycle
                if (bus_ack_i) begin
                    state_d  = S_DONE;
                    complete = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    abort   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = G_NONE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = G_NONE;
            end
        endcase
    end

    // latched request; only reloaded when a new bus cycle is granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_we_q   <= 1'b0;
            req_sel_q  <= 4'b0000;
            req_addr_q <= 32'h0;
            req_data_q <= 32'h0;
        end else if (latch_req) begin
            req_we_q   <= lat_we;
            req_sel_q  <= lat_sel;
            req_addr_q <= lat_addr;
            req_data_q <= lat_data;
        end
    end

    // per-port read data: loaded on a read ack, zeroed on a timeout abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_data_q  <= 32'h0;
            mem_data_q <= 32'h0;
        end else if (complete && !req_we_q) begin
            if (grant_q == G_INST) if_data_q  <= bus_data_i;
            if (grant_q == G_DATA) mem_data_q <= bus_data_i;
        end else if (abort) begin
            if (grant_q == G_INST) if_data_q  <= 32'h0;
            if (grant_q == G_DATA) mem_data_q <= 32'h0;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt_q;
    logic          err_q;

    // counts completed BUSY cycles; zero whenever a new cycle starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_BUSY) begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    // this BUSY cycle is the last one allowed
    assign timeout_hit = (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // error pulse coincides with the DONE cycle that follows an abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
        end
    end

    assign bus_err_o = err_q;
`else
    // without the timeout build the parameter has no effect
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
    assign bus_err_o   = 1'b0;
`endif

    // bus drive: everything zero outside BUSY, latched request inside it
    logic busy;
    assign busy       = (state_q == S_BUSY);
    assign bus_cyc_o  = busy;
    assign bus_stb_o  = busy;
    assign bus_we_o   = busy & req_we_q;
    assign bus_sel_o  = busy ? req_sel_q  : 4'b0000;
    assign bus_addr_o = busy ? req_addr_q : 32'h0;
    assign bus_data_o = busy ? req_data_q : 32'h0;

    // a requester is released only in the DONE cycle of its own grant
    assign if_stall_req_o  = if_ce_i  & ~((state_q == S_DONE) && (grant_q == G_INST));
    assign mem_stall_req_o = mem_ce_i & ~((state_q == S_DONE) && (grant_q == G_DATA));

    assign if_data_o   = if_data_q;
    assign mem_data_o  = mem_data_q;
    assign dbg_state_o = state_q;
    assign dbg_grant_o = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs change just after the falling
// edge; outputs are checked at the falling edge (or shortly after an input
// change for the combinational stall paths).
module tb_mem_bus_arbiter;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] GR_NONE = 2'd0;
    localparam logic [1:0] GR_INST = 2'd1;
    localparam logic [1:0] GR_DATA = 2'd2;

    logic        clk;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_stall_req_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_stall_req_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        bus_err_o;
    logic [1:0]  dbg_state_o;
    logic [1:0]  dbg_grant_o;

    int vectors;
    int miscompares;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_ce_i         (if_ce_i),
        .if_addr_i       (if_addr_i),
        .if_data_o       (if_data_o),
        .if_stall_req_o  (if_stall_req_o),
        .mem_ce_i        (mem_ce_i),
        .mem_we_i        (mem_we_i),
        .mem_sel_i       (mem_sel_i),
        .mem_addr_i      (mem_addr_i),
        .mem_data_i      (mem_data_i),
        .mem_data_o      (mem_data_o),
        .mem_stall_req_o (mem_stall_req_o),
        .bus_cyc_o       (bus_cyc_o),
        .bus_stb_o       (bus_stb_o),
        .bus_we_o        (bus_we_o),
        .bus_sel_o       (bus_sel_o),
        .bus_addr_o      (bus_addr_o),
        .bus_data_o      (bus_data_o),
        .bus_data_i      (bus_data_i),
        .bus_ack_i       (bus_ack_i),
        .bus_err_o       (bus_err_o),
        .dbg_state_o     (dbg_state_o),
        .dbg_grant_o     (dbg_grant_o)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst        = 1'b0;
        if_ce_i    = 1'b1;
        if_addr_i  = 32'h0;
        mem_ce_i   = 1'b0;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'h0;
        mem_addr_i = 32'h0;
        mem_data_i = 32'h0;
        bus_data_i = 32'h0;
        bus_ack_i  = 1'b0;

        // ---- reset state ----
        #3;
        chk("rst_cyc", {31'h0, bus_cyc_o}, 32'h0);
        chk("rst_stb", {31'h0, bus_stb_o}, 32'h0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_if_data", if_data_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 32'h0);
        chk("rst_err", {31'h0, bus_err_o}, 32'h0);
        chk("rst_if_stall", {31'h0, if_stall_req_o}, 32'h1);
        chk("rst_mem_stall", {31'h0, mem_stall_req_o}, 32'h0);
        step();
        step();
        chk("rst_hold_state", {30'h0, dbg_state_o}, {30'h0, ST_IDLE});
        chk("rst_hold_grant", {30'h0, dbg_grant_o}, {30'h0, GR_NONE});
        if_ce_i = 1'b0;
        rst     = 1'b1;
        step();

        // ---- spurious ack in IDLE ----
        bus_ack_i  = 1'b1;
        bus_data_i = 32'hDEADBEEF;
        step();
        chk("spur_state", {30'h0, dbg_state_o}, {30'h0, ST_IDLE});
        chk("spur_cyc", {31'h0, bus_cyc_o}, 32'h0);
        chk("spur_if_data", if_data_o, 32'h0);
        chk("spur_mem_data", mem_data_o, 32'h0);
        bus_ack_i = 1'b0;

        // ---- fetch only ----
        if_ce_i   = 1'b1;
        if_addr_i = 32'h100;
        #1;
        chk("fetch_stall_idle", {31'h0, if_stall_req_o}, 32'h1);
        step();
        chk("fetch_state_busy", {30'h0, dbg_state_o}, {30'h0, ST_BUSY});
        chk("fetch_cyc", {31'h0, bus_cyc_o}, 32'h1);
        chk("fetch_stb", {31'h0, bus_stb_o}, 32'h1);
        chk("fetch_addr", bus_addr_o, 32'h100);
        chk("fetch_we", {31'h0, bus_we_o}, 32'h0);
        chk("fetch_sel", {28'h0, bus_sel_o}, 32'hF);
        chk("fetch_stall_busy", {31'h0, if_stall_req_o}, 32'h1);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h24020005;
        step();
        chk("fetch_state_done", {30'h0, dbg_state_o}, {30'h0, ST_DONE});
        chk("fetch_cyc_done", {31'h0, bus_cyc_o}, 32'h0);
        chk("fetch_data", if_data_o, 32'h24020005);
        chk("fetch_stall_done", {31'h0, if_stall_req_o}, 32'h0);
        bus_ack_i  = 1'b0;
        bus_data_i = 32'h0;
        step();
        chk("fetch_state_idle", {30'h0, dbg_state_o}, {30'h0, ST_IDLE});
        chk("fetch_grant_none", {30'h0, dbg_grant_o}, {30'h0, GR_NONE});
        chk("fetch_stall_after", {31'h0, if_stall_req_o}, 32'h1);
        chk("fetch_data_hold", if_data_o, 32'h24020005);
        if_ce_i = 1'b0;
        step();

        // ---- collision: data first, then fetch ----
        if_ce_i    = 1'b1;
        if_addr_i  = 32'h100;
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h200;
        step();
        chk("col_grant_data", {30'h0, dbg_grant_o}, {30'h0, GR_DATA});
        chk("col_addr_data", bus_addr_o, 32'h200);
        chk("col_if_stall_1", {31'h0, if_stall_req_o}, 32'h1);
        chk("col_mem_stall_busy", {31'h0, mem_stall_req_o}, 32'h1);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h11223344;
        step();
        chk("col_mem_data", mem_data_o, 32'h11223344);
        chk("col_mem_stall_done", {31'h0, mem_stall_req_o}, 32'h0);
        chk("col_if_stall_2", {31'h0, if_stall_req_o}, 32'h1);
        chk("col_if_data_keep", if_data_o, 32'h24020005);
        mem_ce_i  = 1'b0;
        bus_ack_i = 1'b0;
        step();
        chk("col_idle", {30'h0, dbg_state_o}, {30'h0, ST_IDLE});
        chk("col_if_stall_3", {31'h0, if_stall_req_o}, 32'h1);
        step();
        chk("col_grant_inst", {30'h0, dbg_grant_o}, {30'h0, GR_INST});
        chk("col_addr_fetch", bus_addr_o, 32'h100);
        chk("col_if_stall_4", {31'h0, if_stall_req_o}, 32'h1);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h55667788;
        step();
        chk("col_if_data", if_data_o, 32'h55667788);
        chk("col_if_stall_done", {31'h0, if_stall_req_o}, 32'h0);
        chk("col_mem_data_keep", mem_data_o, 32'h11223344);
        if_ce_i   = 1'b0;
        bus_ack_i = 1'b0;
        step();

        // ---- store with three wait cycles; inputs change mid-cycle ----
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b1;
        mem_sel_i  = 4'b0100;
        mem_addr_i = 32'h300;
        mem_data_i = 32'h00AB0000;
        step();
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h999;
        mem_data_i = 32'h0;
        bus_data_i = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("st_we_%0d", i), {31'h0, bus_we_o}, 32'h1);
            chk($sformatf("st_sel_%0d", i), {28'h0, bus_sel_o}, 32'h4);
            chk($sformatf("st_addr_%0d", i), bus_addr_o, 32'h300);
            chk($sformatf("st_wdata_%0d", i), bus_data_o, 32'h00AB0000);
            if (i == 3) bus_ack_i = 1'b1;
            step();
        end
        chk("st_done", {30'h0, dbg_state_o}, {30'h0, ST_DONE});
        chk("st_mem_data_keep", mem_data_o, 32'h11223344);
        chk("st_cyc_done", {31'h0, bus_cyc_o}, 32'h0);
        mem_ce_i  = 1'b0;
        bus_ack_i = 1'b0;
        step();

        // ---- fetch abandoned mid-cycle still completes ----
        if_ce_i   = 1'b1;
        if_addr_i = 32'h400;
        step();
        if_ce_i = 1'b0;
        step();
        chk("aband_cyc", {31'h0, bus_cyc_o}, 32'h1);
        chk("aband_addr", bus_addr_o, 32'h400);
        bus_ack_i  = 1'b1;
        bus_data_i = 32'hAAAA5555;
        step();
        chk("aband_done", {30'h0, dbg_state_o}, {30'h0, ST_DONE});
        chk("aband_if_data", if_data_o, 32'hAAAA5555);
        bus_ack_i = 1'b0;
        step();

        // ---- reset in the middle of BUSY ----
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'hF;
        mem_addr_i = 32'h500;
        step();
        step();
        chk("rmid_cyc_before", {31'h0, bus_cyc_o}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("rmid_cyc", {31'h0, bus_cyc_o}, 32'h0);
        chk("rmid_stb", {31'h0, bus_stb_o}, 32'h0);
        chk("rmid_state", {30'h0, dbg_state_o}, {30'h0, ST_IDLE});
        chk("rmid_mem_stall", {31'h0, mem_stall_req_o}, 32'h1);
        chk("rmid_if_data", if_data_o, 32'h0);
        mem_ce_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rmid_idle_after", {30'h0, dbg_state_o}, {30'h0, ST_IDLE});
        chk("rmid_cyc_after", {31'h0, bus_cyc_o}, 32'h0);
        chk("rmid_mem_data", mem_data_o, 32'h0);

        // ---- no ack: timeout abort or indefinite wait ----
        mem_ce_i   = 1'b1;
        mem_addr_i = 32'h600;
        bus_data_i = 32'h0BADF00D;
        step();
`ifdef BUS_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("tmo_cyc_%0d", i), {31'h0, bus_cyc_o}, 32'h1);
            chk($sformatf("tmo_err_%0d", i), {31'h0, bus_err_o}, 32'h0);
            step();
        end
        chk("tmo_done", {30'h0, dbg_state_o}, {30'h0, ST_DONE});
        chk("tmo_err_pulse", {31'h0, bus_err_o}, 32'h1);
        chk("tmo_mem_data", mem_data_o, 32'h0);
        chk("tmo_mem_stall", {31'h0, mem_stall_req_o}, 32'h0);
        chk("tmo_cyc_drop", {31'h0, bus_cyc_o}, 32'h0);
        step();
        chk("tmo_err_end", {31'h0, bus_err_o}, 32'h0);
        chk("tmo_idle", {30'h0, dbg_state_o}, {30'h0, ST_IDLE});
        mem_ce_i = 1'b0;
        step();
        // ack landing in the last allowed cycle counts as a normal ack
        mem_ce_i = 1'b1;
        step();
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) bus_ack_i = 1'b1;
            step();
        end
        chk("tmo_ack_done", {30'h0, dbg_state_o}, {30'h0, ST_DONE});
        chk("tmo_ack_err", {31'h0, bus_err_o}, 32'h0);
        chk("tmo_ack_data", mem_data_o, 32'h0BADF00D);
        bus_ack_i = 1'b0;
        mem_ce_i  = 1'b0;
        step();
`else
        for (int i = 1; i <= 20; i++) begin
            chk($sformatf("wait_cyc_%0d", i), {31'h0, bus_cyc_o}, 32'h1);
            chk($sformatf("wait_stall_%0d", i), {31'h0, mem_stall_req_o}, 32'h1);
            chk($sformatf("wait_err_%0d", i), {31'h0, bus_err_o}, 32'h0);
            step();
        end
        bus_ack_i = 1'b1;
        step();
        chk("wait_done", {30'h0, dbg_state_o}, {30'h0, ST_DONE});
        chk("wait_mem_data", mem_data_o, 32'h0BADF00D);
        chk("wait_stall_rel", {31'h0, mem_stall_req_o}, 32'h0);
        bus_ack_i = 1'b0;
        mem_ce_i  = 1'b0;
        step();
`endif
        chk("final_idle", {30'h0, dbg_state_o}, {30'h0, ST_IDLE});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
